tsp_move_scheduler: RTL and testbench

- Sequencer for the 2-opt/swap local search. Sits between the xorshift RNG, the path register file and the checkswap evaluator.
- Draws legal candidate index pairs, launches one evaluation at a time over a req/ack handshake, and issues a one-cycle commit strobe when the evaluator accepts the swap.
- Counts iterations, accepted swaps and total gain. Stops after max_iters evaluations or on a stop request.

---
 rtl/tsp_pkg.sv | 25 ++
 rtl/tsp_pair_gen.sv | 38 +++
 rtl/tsp_move_scheduler.sv | 132 +++++++++++++
 tb/tb_tsp_move_scheduler.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsp_pkg.sv
// Shared constants, state encoding and index helpers for the 2-opt move scheduler.
package tsp_pkg;

  localparam int unsigned N_CITIES = 64;
  localparam int unsigned IDX_W    = 6;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DRAW1  = 3'd1;
  localparam logic [2:0] DRAW2  = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] ISSUE  = 3'd4;
  localparam logic [2:0] WAIT   = 3'd5;
  localparam logic [2:0] COMMIT = 3'd6;
  localparam logic [2:0] FINISH = 3'd7;

  // Slots 0 and N-1 are never drawn, so candidates land in 1..N-2.
  function automatic int unsigned idx_from_rnd(logic [31:0] r, int unsigned n_cities);
    return (r % (n_cities - 32'd2)) + 32'd1;
  endfunction

  function automatic logic pair_legal(int unsigned v1, int unsigned v2);
    return (v1 != v2) && (v1 != v2 + 32'd1) && (v2 != v1 + 32'd1);
  endfunction

endpackage

// File: rtl/tsp_pair_gen.sv
// Draws candidate indices from the RNG and flags when the held pair is a legal 2-opt move.
module tsp_pair_gen
  import tsp_pkg::*;
#(
  parameter int unsigned N_CITIES = tsp_pkg::N_CITIES,
  parameter int unsigned IDX_W    = tsp_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      rnd,
  input  logic             draw1,
  input  logic             draw2,
  input  logic             check,
  output logic [IDX_W-1:0] pair_lo,
  output logic [IDX_W-1:0] pair_hi,
  output logic             pair_valid
);

  logic [IDX_W-1:0] v1_q, v2_q;
  logic [IDX_W-1:0] idx;

  assign idx        = IDX_W'(idx_from_rnd(rnd, N_CITIES));
  assign pair_valid = pair_legal(32'(v1_q), 32'(v2_q));
  assign pair_lo    = (v1_q < v2_q) ? v1_q : v2_q;
  assign pair_hi    = (v1_q < v2_q) ? v2_q : v1_q;

  // v1 stays fixed; only v2 is redrawn until the pair becomes legal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= '0;
      v2_q <= '0;
    end else begin
      if (draw1) v1_q <= idx;
      if (draw2 || (check && !pair_valid)) v2_q <= idx;
    end
  end

endmodule

// File: rtl/tsp_move_scheduler.sv
// Local-search sequencer: draws legal pairs, runs one evaluation at a time, commits accepted swaps.
module tsp_move_scheduler
  import tsp_pkg::*;
#(
  parameter int unsigned N_CITIES = tsp_pkg::N_CITIES,
  parameter int unsigned IDX_W    = tsp_pkg::IDX_W,
  parameter int unsigned ITER_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [ITER_W-1:0] max_iters,
  input  logic [31:0]       rnd,
  output logic              eval_req,
  input  logic              eval_ack,
  output logic [IDX_W-1:0]  eval_v1,
  output logic [IDX_W-1:0]  eval_v2,
  input  logic              eval_done,
  input  logic              eval_accept,
  input  logic [31:0]       eval_gain,
  output logic              swap_en,
  output logic [IDX_W-1:0]  swap_a,
  output logic [IDX_W-1:0]  swap_b,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_cnt,
  output logic [ITER_W-1:0] accept_cnt,
  output logic [31:0]       gain_total
);

  logic [2:0]        state_q, state_d;
  logic              stop_pending_q;
  logic [ITER_W-1:0] max_q;
  logic [31:0]       gain_q;
  logic [IDX_W-1:0]  pair_lo, pair_hi;
  logic              pair_valid;
  logic              stop_any;
  logic              last_iter;

  tsp_pair_gen #(
    .N_CITIES(N_CITIES),
    .IDX_W   (IDX_W)
  ) u_pair_gen (
    .clk       (clk),
    .rst       (rst),
    .rnd       (rnd),
    .draw1     (state_q == DRAW1),
    .draw2     (state_q == DRAW2),
    .check     (state_q == CHECK),
    .pair_lo   (pair_lo),
    .pair_hi   (pair_hi),
    .pair_valid(pair_valid)
  );

  // A stop arriving this cycle counts as well as one latched earlier.
  assign stop_any  = stop_pending_q | stop;
  assign last_iter = (iter_cnt + ITER_W'(1)) == max_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = (max_iters == '0) ? FINISH : DRAW1;
      DRAW1:  state_d = stop_any ? FINISH : DRAW2;
      DRAW2:  state_d = stop_any ? FINISH : CHECK;
      CHECK: begin
        if (stop_any)        state_d = FINISH;
        else if (pair_valid) state_d = ISSUE;
      end
      ISSUE:  if (eval_ack) state_d = WAIT;
      WAIT: begin
        if (eval_done) begin
          if (eval_accept)                state_d = COMMIT;
          else if (last_iter || stop_any) state_d = FINISH;
          else                            state_d = DRAW1;
        end
      end
      COMMIT: state_d = ((iter_cnt == max_q) || stop_any) ? FINISH : DRAW1;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      stop_pending_q <= 1'b0;
      max_q          <= '0;
      gain_q         <= '0;
      eval_v1        <= '0;
      eval_v2        <= '0;
      iter_cnt       <= '0;
      accept_cnt     <= '0;
      gain_total     <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE || state_q == FINISH) stop_pending_q <= 1'b0;
      else if (stop)                            stop_pending_q <= 1'b1;

      if (state_q == IDLE && start) begin
        iter_cnt   <= '0;
        accept_cnt <= '0;
        gain_total <= '0;
        max_q      <= max_iters;
      end

      if (state_q == CHECK && pair_valid) begin
        eval_v1 <= pair_lo;
        eval_v2 <= pair_hi;
      end

      if (state_q == WAIT && eval_done) begin
        iter_cnt <= iter_cnt + ITER_W'(1);
        gain_q   <= eval_gain;
      end

      if (state_q == COMMIT) begin
        accept_cnt <= accept_cnt + ITER_W'(1);
        gain_total <= gain_total + gain_q;
      end
    end
  end

  assign eval_req = (state_q == ISSUE);
  assign swap_en  = (state_q == COMMIT);
  assign swap_a   = eval_v1;
  assign swap_b   = eval_v2;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);

endmodule

// File: tb/tb_tsp_move_scheduler.sv
// Randomized self-checking bench for tsp_move_scheduler against a behavioural pair/counter model.
module tb_tsp_move_scheduler;

  localparam int unsigned IDX_W  = 6;
  localparam int unsigned ITER_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, stop;
  logic [ITER_W-1:0] max_iters;
  logic [31:0]       rnd;
  logic              eval_req, eval_ack;
  logic [IDX_W-1:0]  eval_v1, eval_v2;
  logic              eval_done, eval_accept;
  logic [31:0]       eval_gain;
  logic              swap_en;
  logic [IDX_W-1:0]  swap_a, swap_b;
  logic              busy, done;
  logic [ITER_W-1:0] iter_cnt, accept_cnt;
  logic [31:0]       gain_total;

  always #5 clk = ~clk;

  tsp_move_scheduler #(
    .N_CITIES(64),
    .IDX_W   (IDX_W),
    .ITER_W  (ITER_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .max_iters  (max_iters),
    .rnd        (rnd),
    .eval_req   (eval_req),
    .eval_ack   (eval_ack),
    .eval_v1    (eval_v1),
    .eval_v2    (eval_v2),
    .eval_done  (eval_done),
    .eval_accept(eval_accept),
    .eval_gain  (eval_gain),
    .swap_en    (swap_en),
    .swap_a     (swap_a),
    .swap_b     (swap_b),
    .busy       (busy),
    .done       (done),
    .iter_cnt   (iter_cnt),
    .accept_cnt (accept_cnt),
    .gain_total (gain_total)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned swap_pulses = 0;
  logic [31:0] rnd_q[$];
  logic [31:0] fixed_q[$];
  bit          sc_acc [16];
  logic [31:0] sc_gain [16];

  always @(posedge clk) begin
    if (!rst) assert (!(eval_done && eval_ack)) else $error("eval_done concurrent with eval_ack");
  end

  always @(negedge clk) if (swap_en === 1'b1) swap_pulses++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned idx_m(logic [31:0] r);
    return (r % 32'd62) + 32'd1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    rnd = (rnd_q.size() != 0) ? rnd_q.pop_front() : $urandom;
  endtask

  // Loads the RNG script seen from the next DRAW1 onwards and predicts the pair it yields.
  task automatic push_script(output int unsigned lo, output int unsigned hi,
                             output int unsigned k);
    logic [31:0] s[$];
    logic [31:0] r0;
    int unsigned a, b;
    if (fixed_q.size() != 0) begin
      s = fixed_q;
      fixed_q.delete();
    end else begin
      r0 = $urandom;
      s.push_back(r0);
      for (int i = 0; i < 30; i++)
        s.push_back($urandom_range(0, 1) ? r0 + $urandom_range(0, 2) : $urandom);
    end
    a = idx_m(s[0]);
    b = 0;
    k = 0;
    for (int i = 1; i < s.size(); i++) begin
      b = idx_m(s[i]);
      if (b != a && b != a + 1 && a != b + 1) begin
        k = i;
        break;
      end
    end
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    rnd_q = s;
  endtask

  task automatic run_scenario(input string name, input int unsigned maxit, input int ack_d,
                              input bit inject, input int stop_iter);
    int unsigned lo, hi, k, d, lat, exp_iter, exp_acc, pulses0;
    logic [31:0] exp_gain;
    bit early, unstable, fin, stopped, acc;
    exp_iter = 0;
    exp_acc  = 0;
    exp_gain = 0;
    fin      = 0;
    pulses0  = swap_pulses;
    start     = 1'b1;
    max_iters = maxit;
    push_script(lo, hi, k);
    while (!fin) begin
      early = 0;
      for (int s = 1; s <= 3 + int'(k); s++) begin
        step();
        start = 0; eval_done = 0; eval_accept = 0; stop = 0;
        if (s < 3 + int'(k) && eval_req) early = 1;
      end
      n_checks++;
      if (early !== 1'b0 || eval_req !== 1'b1) begin
        n_fail++;
        $display("FAIL %s req_latency: got early=%0b req=%0b want early=0 req=1 after %0d cycles",
                 name, early, eval_req, 3 + k);
      end
      n_checks++;
      if (32'(eval_v1) !== lo || 32'(eval_v2) !== hi) begin
        n_fail++;
        $display("FAIL %s pair: got (%0d,%0d) want (%0d,%0d)", name, eval_v1, eval_v2, lo, hi);
      end
      d = (ack_d >= 0) ? ack_d : $urandom_range(0, 3);
      unstable = 0;
      for (int j = 0; j < int'(d); j++) begin
        if (inject && j == 0) begin
          eval_done = 1; eval_accept = 1; eval_gain = 32'h0000_dead;
        end
        step();
        eval_done = 0; eval_accept = 0;
        if (eval_req !== 1'b1 || 32'(eval_v1) !== lo || 32'(eval_v2) !== hi) unstable = 1;
      end
      n_checks++;
      if (unstable !== 1'b0) begin
        n_fail++;
        $display("FAIL %s backpressure_hold: got unstable=%0b want 0", name, unstable);
      end
      eval_ack = 1;
      if ($urandom_range(0, 1) == 1) begin
        start = 1; max_iters = maxit + 5;
      end
      step();
      eval_ack = 0; start = 0;
      n_checks++;
      if (eval_req !== 1'b0) begin
        n_fail++;
        $display("FAIL %s req_drop: got %0b want 0", name, eval_req);
      end
      lat = $urandom_range(1, 3);
      stopped = (stop_iter >= 0) && (int'(exp_iter) == stop_iter);
      if (stopped) stop = 1;
      for (int j = 1; j < int'(lat); j++) begin
        step();
        stop = 0;
      end
      acc = sc_acc[exp_iter % 16];
      eval_done = 1; eval_accept = acc; eval_gain = sc_gain[exp_iter % 16];
      exp_iter++;
      fin = (exp_iter == maxit) || stopped;
      if (acc) begin
        exp_acc++;
        exp_gain += eval_gain;
        step();
        eval_done = 0; eval_accept = 0; stop = 0;
        n_checks++;
        if (swap_en !== 1'b1 || 32'(swap_a) !== lo || 32'(swap_b) !== hi) begin
          n_fail++;
          $display("FAIL %s commit: got en=%0b a=%0d b=%0d want en=1 a=%0d b=%0d",
                   name, swap_en, swap_a, swap_b, lo, hi);
        end
        if (!fin) push_script(lo, hi, k);
        else step();
      end else begin
        if (!fin) push_script(lo, hi, k);
        else begin
          step();
          eval_done = 0; eval_accept = 0; stop = 0;
        end
      end
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1 || eval_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse: got done=%0b busy=%0b req=%0b want 1 1 0",
               name, done, busy, eval_req);
    end
    n_checks++;
    if (iter_cnt !== exp_iter || accept_cnt !== exp_acc || gain_total !== exp_gain) begin
      n_fail++;
      $display("FAIL %s counters: got iter=%0d acc=%0d gain=%h want iter=%0d acc=%0d gain=%h",
               name, iter_cnt, accept_cnt, gain_total, exp_iter, exp_acc, exp_gain);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || swap_pulses - pulses0 !== exp_acc) begin
      n_fail++;
      $display("FAIL %s idle_after: got done=%0b busy=%0b swaps=%0d want 0 0 %0d",
               name, done, busy, swap_pulses - pulses0, exp_acc);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({eval_req, swap_en, busy, done, eval_v1, eval_v2, swap_a, swap_b,
         iter_cnt, accept_cnt, gain_total} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%0b en=%0b busy=%0b done=%0b iter=%0d want all 0",
               eval_req, swap_en, busy, done, iter_cnt);
    end
  endtask

  task automatic test_basic();
    fixed_q = {32'd10, 32'd40};
    sc_acc[0] = 1; sc_gain[0] = 32'd7;
    run_scenario("basic", 1, 2, 0, -1);
    n_checks++;
    if (iter_cnt !== 32'd1 || accept_cnt !== 32'd1 || gain_total !== 32'd7) begin
      n_fail++;
      $display("FAIL basic_hold: got iter=%0d acc=%0d gain=%0d want 1 1 7",
               iter_cnt, accept_cnt, gain_total);
    end
  endtask

  task automatic test_reject();
    fixed_q = {32'd10, 32'd10, 32'd11, 32'd50};
    sc_acc[0] = 0; sc_gain[0] = 32'd3;
    run_scenario("reject", 1, 0, 0, -1);
  endtask

  task automatic test_backpressure();
    sc_acc[0] = 1; sc_gain[0] = 32'd9;
    run_scenario("backpressure", 1, 5, 1, -1);
  endtask

  task automatic test_wrap();
    sc_acc[0] = 1; sc_gain[0] = 32'hffff_ffff;
    sc_acc[1] = 0; sc_gain[1] = 32'd5;
    sc_acc[2] = 1; sc_gain[2] = 32'd2;
    run_scenario("wrap", 3, -1, 0, -1);
    n_checks++;
    if (gain_total !== 32'd1 || accept_cnt !== 32'd2 || iter_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL wrap_total: got gain=%0d acc=%0d iter=%0d want 1 2 3",
               gain_total, accept_cnt, iter_cnt);
    end
  endtask

  task automatic test_stop_wait();
    sc_acc[0] = 1; sc_gain[0] = 32'd4;
    run_scenario("stop_wait", 100, -1, 0, 0);
    n_checks++;
    if (iter_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL stop_wait_iter: got %0d want 1", iter_cnt);
    end
  endtask

  task automatic test_stop_draw2();
    int unsigned lo, hi, k, dones;
    bit seen_req;
    fixed_q = {32'd10, 32'd40};
    start = 1; max_iters = 100;
    push_script(lo, hi, k);
    step();
    start = 0;
    step();
    stop = 1;
    seen_req = 0;
    dones = 0;
    for (int j = 0; j < 6; j++) begin
      step();
      stop = 0;
      if (eval_req) seen_req = 1;
      if (done) dones++;
    end
    n_checks++;
    if (seen_req !== 1'b0 || dones !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_draw2: got req_seen=%0b dones=%0d busy=%0b want 0 1 0",
               seen_req, dones, busy);
    end
    n_checks++;
    if (iter_cnt !== 32'd0 || accept_cnt !== 32'd0 || gain_total !== 32'd0) begin
      n_fail++;
      $display("FAIL stop_draw2_counters: got iter=%0d acc=%0d gain=%0d want 0 0 0",
               iter_cnt, accept_cnt, gain_total);
    end
  endtask

  task automatic test_zero_iters();
    start = 1; max_iters = 0;
    step();
    start = 0;
    n_checks++;
    if (done !== 1'b1 || eval_req !== 1'b0 || iter_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL zero_iters_done: got done=%0b req=%0b iter=%0d want 1 0 0",
               done, eval_req, iter_cnt);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || eval_req !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_iters_idle: got done=%0b busy=%0b req=%0b want 0 0 0",
               done, busy, eval_req);
    end
  endtask

  task automatic test_random();
    int unsigned m;
    int si;
    for (int r = 0; r < 8; r++) begin
      m = $urandom_range(1, 6);
      for (int i = 0; i < 16; i++) begin
        sc_acc[i]  = $urandom_range(0, 1);
        sc_gain[i] = $urandom;
      end
      si = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, m - 1)) : -1;
      run_scenario("random", m, -1, $urandom_range(0, 1), si);
    end
  endtask

  task automatic test_reset_mid_issue();
    int unsigned lo, hi, k;
    fixed_q = {32'd10, 32'd40};
    start = 1; max_iters = 1;
    push_script(lo, hi, k);
    for (int s = 0; s < 4; s++) begin
      step();
      start = 0;
    end
    n_checks++;
    if (eval_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_issue_pre: got req=%0b want 1", eval_req);
    end
    #2 rst = 1;
    #1;
    n_checks++;
    if ({eval_req, swap_en, busy, done, eval_v1, eval_v2, swap_a, swap_b,
         iter_cnt, accept_cnt, gain_total} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_issue: got req=%0b busy=%0b v1=%0d v2=%0d want all 0",
               eval_req, busy, eval_v1, eval_v2);
    end
    @(posedge clk);
    #3 rst = 0;
    rnd_q.delete();
    step();
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; max_iters = 0; rnd = 0;
    eval_ack = 0; eval_done = 0; eval_accept = 0; eval_gain = 0;
    #12;
    test_reset();
    #6 rst = 0;
    step();
    test_basic();
    test_reject();
    test_backpressure();
    test_wrap();
    test_stop_wait();
    test_stop_draw2();
    test_zero_iters();
    test_random();
    test_reset_mid_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
